// File: rtl/data_sync_tx_scheduler.sv
// Source-side scheduler for a shared enable-qualified CDC bus: round-robin grant,
// word capture, then a fixed enable-high hold window followed by an enable-low gap.
module data_sync_tx_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         sched_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]   bus_q, bus_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  // The last-served index doubles as the round-robin pointer: both are
  // loaded with the winner on every transfer and reset to NUM_REQ-1.
  logic [ID_W-1:0]        gid_q, gid_d;

  logic                   found_hi, found_lo, pick_found;
  logic [ID_W-1:0]        idx_hi, idx_lo, pick_idx;
  logic [BUS_WIDTH-1:0]   pick_word;
  logic                   grant_ok;
  logic                   take;

  // Search above the pointer first, then wrap to the indices at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && req_valid[i] && (i > int'(gid_q))) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(i);
      end
      if (!found_lo && req_valid[i] && (i <= int'(gid_q))) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(i);
      end
    end
    pick_found = found_hi | found_lo;
    pick_idx   = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        pick_word = req_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Handshake: a requester holds req_valid/req_data steady until it sees its
  // req_ready bit; the word transfers on the CLK edge where both are high.
  assign grant_ok = (state_q == ST_IDLE) && sched_en && !RST && pick_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_ok && (pick_idx == ID_W'(i));
    end
  end

  assign take = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    busy_d  = busy_q;
    gid_d   = gid_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          bus_d   = pick_word;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          gid_d   = pick_idx;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      gid_q   <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
    end
  end

  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign grant_id   = gid_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_sync_tx_scheduler.sv
// Directed bench for data_sync_tx_scheduler with default parameters: a per-cycle
// vector table for reset/single word/sched_en/abort, then a modelled round-robin run.
module tb_data_sync_tx_scheduler;

  logic        CLK;
  logic        RST;
  logic        sched_en;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  unsync_bus;
  logic        bus_enable;
  logic [0:0]  grant_id;
  logic        busy;
  logic [1:0]  dbg_state;

  data_sync_tx_scheduler #(
    .NUM_REQ(2), .BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .sched_en(sched_en), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .unsync_bus(unsync_bus),
    .bus_enable(bus_enable), .grant_id(grant_id), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic        sen;
    logic [1:0]  vld;
    logic [15:0] dat;
    logic [1:0]  e_rdy;
    logic        e_en;
    logic [7:0]  e_bus;
    logic        e_gid;
    logic        e_busy;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  // scoreboard: expected observation word {ready, en, bus, gid, busy, state}
  logic [14:0] exp_q[$];

  function automatic vec_t mk(logic rst, logic sen, logic [1:0] vld, logic [15:0] dat,
                              logic [1:0] rdy, logic en, logic [7:0] bus, logic gid,
                              logic bsy, logic [1:0] st);
    vec_t v;
    v.rst = rst; v.sen = sen; v.vld = vld; v.dat = dat;
    v.e_rdy = rdy; v.e_en = en; v.e_bus = bus; v.e_gid = gid; v.e_busy = bsy; v.e_st = st;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic sen, input logic [1:0] vld,
                       input logic [15:0] dat);
    @(negedge CLK);
    RST = rst; sched_en = sen; req_valid = vld; req_data = dat;
    #1;
  endtask

  task automatic check(input string name);
    logic [14:0] got, exp;
    got = {req_ready, bus_enable, unsync_bus, grant_id, busy, dbg_state};
    exp = exp_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b en=%b bus=%h gid=%b busy=%b st=%0d, want rdy=%b en=%b bus=%h gid=%b busy=%b st=%0d",
               name, got[14:13], got[12], got[11:4], got[3], got[2], got[1:0],
               exp[14:13], exp[12], exp[11:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  function automatic logic rr_gid(int m);
    return (m <= 4) ? logic'(m % 2) : 1'b0;
  endfunction

  initial begin
    RST = 1'b1; sched_en = 1'b1; req_valid = 2'b11; req_data = 16'h2211;

    // reset with both requesters valid
    vecs.push_back(mk(1, 1, 2'b11, 16'h2211, 2'b00, 0, 8'h00, 1, 0, 2'd0));
    // first grant after reset goes to requester 0
    vecs.push_back(mk(0, 1, 2'b11, 16'h22A5, 2'b01, 0, 8'h00, 1, 0, 2'd0));
    // HOLD: req0 data changed to FF must not leak; sched_en drops mid-hold
    vecs.push_back(mk(0, 1, 2'b01, 16'h00FF, 2'b00, 1, 8'hA5, 0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 2'b01, 16'h00FF, 2'b00, 1, 8'hA5, 0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 2'b01, 16'h00FF, 2'b00, 1, 8'hA5, 0, 1, 2'd1));
    vecs.push_back(mk(0, 0, 2'b01, 16'h00FF, 2'b00, 1, 8'hA5, 0, 1, 2'd1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 2'b01, 16'h00FF, 2'b00, 0, 8'hA5, 0, 1, 2'd2));
    // back in IDLE with sched_en low: no grant
    vecs.push_back(mk(0, 0, 2'b01, 16'h00FF, 2'b00, 0, 8'hA5, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 2'b01, 16'h00FF, 2'b00, 0, 8'hA5, 0, 0, 2'd0));
    // sched_en raised in IDLE: grant in the same cycle
    vecs.push_back(mk(0, 1, 2'b01, 16'h00FF, 2'b01, 0, 8'hA5, 0, 0, 2'd0));
    vecs.push_back(mk(0, 1, 2'b00, 16'h0000, 2'b00, 1, 8'hFF, 0, 1, 2'd1));
    // reset in the second HOLD cycle aborts the word
    vecs.push_back(mk(1, 1, 2'b11, 16'h2211, 2'b00, 1, 8'hFF, 0, 1, 2'd1));
    vecs.push_back(mk(0, 1, 2'b00, 16'h2211, 2'b00, 0, 8'h00, 1, 0, 2'd0));
    vecs.push_back(mk(0, 1, 2'b00, 16'h2211, 2'b00, 0, 8'h00, 1, 0, 2'd0));
    vecs.push_back(mk(0, 1, 2'b11, 16'h2211, 2'b01, 0, 8'h00, 1, 0, 2'd0));

    foreach (vecs[k]) begin
      exp_q.push_back({vecs[k].e_rdy, vecs[k].e_en, vecs[k].e_bus, vecs[k].e_gid,
                       vecs[k].e_busy, vecs[k].e_st});
      drive(vecs[k].rst, vecs[k].sen, vecs[k].vld, vecs[k].dat);
      check($sformatf("vec%0d", k));
    end

    // Continuous traffic: both valid until cycle 36, then only requester 0.
    // Grants every 9 cycles; words alternate 0x11/0x22, then 0x11 repeatedly.
    for (int c = 1; c <= 54; c++) begin
      logic [1:0] e_rdy;
      logic       e_en, e_busy, e_gid;
      logic [1:0] e_st;
      logic [7:0] e_bus;
      int ph;
      ph     = c % 9;
      e_gid  = rr_gid((c - 1) / 9);
      e_bus  = e_gid ? 8'h22 : 8'h11;
      e_en   = (ph >= 1) && (ph <= 4);
      e_busy = (ph != 0);
      e_st   = (ph == 0) ? 2'd0 : (ph <= 4) ? 2'd1 : 2'd2;
      e_rdy  = (ph == 0) ? (rr_gid(c / 9) ? 2'b10 : 2'b01) : 2'b00;
      exp_q.push_back({e_rdy, e_en, e_bus, e_gid, e_busy, e_st});
      drive(0, 1, (c <= 36) ? 2'b11 : 2'b01, 16'h2211);
      check($sformatf("rr_cycle%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sync_tx_scheduler.md
Name: data_sync_tx_scheduler

Overview:
- Source-domain scheduler that shares one multi-bit CDC crossing (enable-qualified bus feeding a destination-domain bus synchronizer) between NUM_REQ requesters.
- Arbitrates round-robin and captures the winner's word.
- Drives unsync_bus/bus_enable with a guaranteed enable-high hold window and enable-low gap, so the destination pulse generator sees exactly one clean rising edge per word, with data stable throughout.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4)
- BUS_WIDTH, 8, data word width
- HOLD_CYCLES, 4, CLK cycles bus_enable stays high per word (legal >=1)
- GAP_CYCLES, 4, CLK cycles bus_enable stays low after HOLD before the next grant (legal >=1)

Ports:
- CLK  in  1  source-domain clock
- RST  in  1  synchronous, active-high reset
- sched_en  in  1  1 = new grants allowed; 0 = finish in-flight word, grant nothing new
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*BUS_WIDTH  flattened words; requester i at bits [i*BUS_WIDTH +: BUS_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept, combinational, IDLE only
- unsync_bus  out  BUS_WIDTH  registered data to the crossing
- bus_enable  out  1  registered enable to the crossing
- grant_id  out  clog2(NUM_REQ)  index of the requester currently/last served
- busy  out  1  high in HOLD or GAP

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high. While RST=1 at a CLK edge:
  - state=IDLE, counter=0, bus_enable=0, unsync_bus=0, grant_id=NUM_REQ-1, busy=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while RST=1.
- Reset mid-HOLD or mid-GAP aborts the word; bus_enable is 0 from that edge.
- FSM states:
  - IDLE: bus_enable=0, busy=0; unsync_bus holds its last value (never changes outside a capture).
  - HOLD: bus_enable=1, busy=1.
  - GAP: bus_enable=0, busy=1.
- Grant (IDLE only):
  - If sched_en=1 and any req_valid=1, req_ready is one-hot on the first valid requester searching from (pointer+1) mod NUM_REQ upward with wrap.
  - Otherwise req_ready=0.
  - req_ready never asserts in HOLD/GAP or when sched_en=0.
- Transfer at edge E0: IDLE with req_valid[i] & req_ready[i].
  - unsync_bus <= word i; grant_id <= i; pointer <= i.
  - bus_enable <= 1; state <= HOLD; counter <= 0.
  - Data and enable rise at the same edge.
- HOLD: counter increments each cycle. At the edge ending the HOLD_CYCLES-th HOLD cycle: bus_enable <= 0, state <= GAP, counter <= 0.
- GAP: at the edge ending the GAP_CYCLES-th GAP cycle: state <= IDLE, busy <= 0.
- Per-word timing:
  - bus_enable high exactly HOLD_CYCLES cycles, then low at least GAP_CYCLES cycles.
  - unsync_bus constant from E0 until the next transfer edge.
  - Minimum spacing between transfer edges = HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Counter width = clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). No wrap occurs because counters reset at each state entry.
- sched_en:
  - Dropping to 0 in HOLD/GAP does not shorten or extend the window.
  - Only grants are inhibited.
  - Raising it in IDLE allows a grant in that same cycle.
- Requester req_valid/req_data changes during HOLD/GAP have no effect. Requesters hold valid/data until they see req_ready.
- All req_valid low in IDLE: stay IDLE, outputs unchanged.
- Single requester valid continuously: served every HOLD_CYCLES+GAP_CYCLES+1 cycles; the pointer does not block it.

Test Plan:
- Reset: assert RST 2 cycles with req_valid=2'b11 -> bus_enable=0, unsync_bus=0, req_ready=0, grant_id=1. First grant after release goes to requester 0.
- Single word (defaults): req0 valid, data 0xA5, sched_en=1 -> req_ready[0]=1 in IDLE; next 4 cycles bus_enable=1, unsync_bus=0xA5; 4 cycles bus_enable=0, busy=1; then IDLE.
- Round-robin (both valid continuously, req0=0x11, req1=0x22) -> words 0x11, 0x22, 0x11, 0x22; transfer edges 9 cycles apart; grant_id alternates 0,1,0,1.
- Data-change immunity: change req_data[0] to 0xFF during HOLD -> unsync_bus stays 0xA5 through HOLD and GAP.
- sched_en drop: sched_en=0 mid-HOLD -> window completes at 4+4 cycles; no req_ready while sched_en=0. sched_en=1 in IDLE -> grant the same cycle.
- Reset mid-operation: RST=1 in the 2nd HOLD cycle -> bus_enable=0 at that edge, state IDLE. Next grant after release goes to requester 0.
